// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC unit: drives a combinational instruction memory and
// fills the IF/ID register, with BOOT/RUN/HALT sequencing and sticky errors.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          IMEM_WORDS   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        halted,
  output logic [1:0]  err_code,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [32:0] PC_LIMIT = 33'(4 * IMEM_WORDS);
  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [1:0]  ERR_NONE      = 2'd0;
  localparam logic [1:0]  ERR_MISALIGN  = 2'd1;
  localparam logic [1:0]  ERR_OOR       = 2'd2;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_out_of_range;
  logic        redirect_aligned;
  logic        fetch_is_ebreak;

  assign imem_addr        = pc;
  assign halted           = (state == HALT);
  assign pc_plus4         = pc + 32'd4;
  assign pc_out_of_range  = ({1'b0, pc} >= PC_LIMIT);
  assign redirect_aligned = (redirect_target[1:0] == 2'b00);
  assign fetch_is_ebreak  = (imem_rdata == EBREAK);

  // Priority in RUN: redirect, then out-of-range PC, then stall, then capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_VECTOR;
      ifid_valid    <= 1'b0;
      ifid_pc       <= 32'd0;
      ifid_instr    <= 32'd0;
      ifid_pc_plus4 <= 32'd0;
      err_code      <= ERR_NONE;
      fetch_count   <= 32'd0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (redirect_valid) begin
            ifid_valid <= 1'b0;
            if (redirect_aligned) begin
              pc <= redirect_target;
            end else begin
              err_code <= ERR_MISALIGN;
              state    <= HALT;
            end
          end else if (pc_out_of_range) begin
            ifid_valid <= 1'b0;
            err_code   <= ERR_OOR;
            state      <= HALT;
          end else if (!stall) begin
            ifid_valid    <= 1'b1;
            ifid_pc       <= pc;
            ifid_instr    <= imem_rdata;
            ifid_pc_plus4 <= pc_plus4;
            fetch_count   <= fetch_count + 32'd1;
            // EBREAK completes its capture but parks the PC on itself.
            if (fetch_is_ebreak) begin
              state <= HALT;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        HALT: ifid_valid <= 1'b0;
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a rule-level model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_fetch_pc_unit;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBRK   = 32'h0010_0073;
  localparam int          WORDS  = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        halted;
  logic [1:0]  err_code;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:WORDS-1];

  int n_tests = 0;
  int n_fail  = 0;
  logic cmp_en = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_VECTOR(32'h0), .IMEM_WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4), .halted(halted), .err_code(err_code),
    .fetch_count(fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'(4 * WORDS)) return mem[a[6:2]];
    return NOP;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // behavioural model: what the fetch unit must show, from its rules
  logic [31:0] m_pc, m_ipc, m_instr, m_pc4, m_count;
  logic        m_valid, m_halted, m_booting;
  logic [1:0]  m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 32'h0; m_ipc <= 32'h0; m_instr <= 32'h0; m_pc4 <= 32'h0;
      m_count <= 32'h0; m_valid <= 1'b0; m_halted <= 1'b0;
      m_booting <= 1'b1; m_err <= 2'd0;
    end else if (m_halted) begin
      m_valid <= 1'b0;
    end else if (m_booting) begin
      m_booting <= 1'b0;
    end else if (redirect_valid) begin
      m_valid <= 1'b0;
      if (redirect_target % 4 == 0) begin
        m_pc <= redirect_target;
      end else begin
        m_err <= 2'd1;
        m_halted <= 1'b1;
      end
    end else if (m_pc >= 32'(4 * WORDS)) begin
      m_valid <= 1'b0;
      m_err <= 2'd2;
      m_halted <= 1'b1;
    end else if (!stall) begin
      m_valid <= 1'b1;
      m_ipc <= m_pc;
      m_instr <= mem_word(m_pc);
      m_pc4 <= m_pc + 32'd4;
      m_count <= m_count + 32'd1;
      if (mem_word(m_pc) == EBRK) m_halted <= 1'b1;
      else m_pc <= m_pc + 32'd4;
    end
  end

  // scoreboard helper
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every cycle, DUT versus model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_ifid_valid", 32'(ifid_valid), 32'(m_valid));
      if (m_valid) begin
        chk("m_ifid_pc", ifid_pc, m_ipc);
        chk("m_ifid_instr", ifid_instr, m_instr);
        chk("m_ifid_pc_plus4", ifid_pc_plus4, m_pc4);
      end
      chk("m_halted", 32'(halted), 32'(m_halted));
      chk("m_err_code", 32'(err_code), 32'(m_err));
      chk("m_fetch_count", fetch_count, m_count);
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic rv, input logic [31:0] rt);
    stall = s;
    redirect_valid = rv;
    redirect_target = rt;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < WORDS; i++) mem[i] = NOP;
  endtask

  task automatic restart();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    cycles(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    fill_nop();
    @(posedge clk);
    cmp_en = 1'b1;
    cycles(1);
    chk("rst_ifid_valid", 32'(ifid_valid), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_count", fetch_count, 32'd0);

    // scenario 1: boot then sequential fetch
    rst_n = 1'b1;
    cycles(1);
    chk("boot_valid", 32'(ifid_valid), 32'd0);
    chk("boot_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      chk("seq_pc", ifid_pc, 32'(4 * i));
      chk("seq_count", fetch_count, 32'(i + 1));
      chk("seq_instr", ifid_instr, NOP);
    end

    // scenario 2: three stalled cycles, then resume at 12
    drive(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      chk("stall_pc", ifid_pc, 32'd8);
      chk("stall_addr", imem_addr, 32'd12);
      chk("stall_count", fetch_count, 32'd3);
    end
    drive(1'b0, 1'b0, 32'h0);
    cycles(1);
    chk("resume_pc", ifid_pc, 32'd12);
    chk("resume_count", fetch_count, 32'd4);

    // scenario 3: redirect wins over stall
    drive(1'b1, 1'b1, 32'h20);
    cycles(1);
    chk("redir_valid", 32'(ifid_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'h20);
    drive(1'b0, 1'b0, 32'h0);
    cycles(1);
    chk("redir_cap_pc", ifid_pc, 32'h20);
    chk("redir_cap_pc4", ifid_pc_plus4, 32'h24);
    chk("redir_cap_count", fetch_count, 32'd5);

    // scenario 4: misaligned redirect halts with err 1
    drive(1'b0, 1'b1, 32'h22);
    cycles(1);
    chk("mis_err", 32'(err_code), 32'd1);
    chk("mis_halted", 32'(halted), 32'd1);
    chk("mis_valid", 32'(ifid_valid), 32'd0);
    chk("mis_addr", imem_addr, 32'h24);
    drive(1'b1, 1'b1, 32'h40);
    cycles(2);
    drive(1'b0, 1'b1, 32'h80);
    cycles(1);
    drive(1'b0, 1'b0, 32'h0);
    cycles(2);
    chk("mis_hold_addr", imem_addr, 32'h24);
    chk("mis_hold_count", fetch_count, 32'd5);
    chk("mis_hold_err", 32'(err_code), 32'd1);

    // scenario 5: EBREAK at word 3
    mem[3] = EBRK;
    restart();
    cycles(1);
    cycles(4);
    chk("ebrk_valid", 32'(ifid_valid), 32'd1);
    chk("ebrk_pc", ifid_pc, 32'd12);
    chk("ebrk_instr", ifid_instr, EBRK);
    chk("ebrk_halted", 32'(halted), 32'd1);
    chk("ebrk_addr", imem_addr, 32'd12);
    chk("ebrk_count", fetch_count, 32'd4);
    cycles(1);
    chk("ebrk_after_valid", 32'(ifid_valid), 32'd0);
    chk("ebrk_after_addr", imem_addr, 32'd12);
    cycles(2);
    chk("ebrk_late_valid", 32'(ifid_valid), 32'd0);
    chk("ebrk_late_count", fetch_count, 32'd4);

    // scenario 6: run off the end of memory, then async reset
    mem[3] = NOP;
    restart();
    cycles(1);
    cycles(32);
    chk("oor_last_pc", ifid_pc, 32'd124);
    chk("oor_count", fetch_count, 32'd32);
    chk("oor_addr", imem_addr, 32'd128);
    chk("oor_pre_halted", 32'(halted), 32'd0);
    cycles(1);
    chk("oor_err", 32'(err_code), 32'd2);
    chk("oor_halted", 32'(halted), 32'd1);
    chk("oor_valid", 32'(ifid_valid), 32'd0);
    chk("oor_hold_count", fetch_count, 32'd32);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_valid", 32'(ifid_valid), 32'd0);
    chk("arst_pc", ifid_pc, 32'h0);
    chk("arst_instr", ifid_instr, 32'h0);
    chk("arst_pc4", ifid_pc_plus4, 32'h0);
    chk("arst_halted", 32'(halted), 32'd0);
    chk("arst_err", 32'(err_code), 32'd0);
    chk("arst_count", fetch_count, 32'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(3);
    chk("post_rst_pc", ifid_pc, 32'd4);
    chk("post_rst_count", fetch_count, 32'd2);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 32, instruction-memory depth in 32-bit words; legal PCs are 0 .. 4*IMEM_WORDS-4.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; rising edge.
- rst_n, in, 1, reset; asynchronous assert, active-low.
- stall, in, 1, downstream not ready; hold PC and the IF/ID register.
- redirect_valid, in, 1, taken branch or jump from downstream.
- redirect_target, in, 32, byte address of the new PC.
- imem_addr, out, 32, byte address to the combinational instruction memory.
- imem_rdata, in, 32, instruction word returned for imem_addr in the same cycle.
- ifid_valid, out, 1, IF/ID register holds a live instruction.
- ifid_pc, out, 32, PC of the captured instruction.
- ifid_instr, out, 32, captured instruction word.
- ifid_pc_plus4, out, 32, ifid_pc + 4, registered.
- halted, out, 1, FSM is in HALT.
- err_code, out, 2, 0 = none, 1 = misaligned redirect, 2 = PC out of range; sticky.
- fetch_count, out, 32, number of instructions captured into IF/ID since reset.
REQ-003 There SHALL be exactly one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 imem_addr SHALL equal the internal PC combinationally; the block SHALL not decode imem_rdata except for the EBREAK compare.
REQ-005 The FSM SHALL have three states: BOOT, RUN, HALT.
REQ-006 BOOT SHALL last exactly one cycle after reset release, with no capture, and SHALL then go to RUN unconditionally.
REQ-007 A capture SHALL occur on a rising edge in RUN when stall=0 and redirect_valid=0; on a capture:
- ifid_instr <= imem_rdata, ifid_pc <= PC, ifid_pc_plus4 <= PC+4;
- ifid_valid <= 1, PC <= PC+4;
- fetch_count <= fetch_count+1.
REQ-008 In RUN with stall=1 and redirect_valid=0, PC, all ifid_* outputs and fetch_count SHALL hold.
REQ-009 In RUN with redirect_valid=1 and redirect_target[1:0]=0, the block SHALL set PC <= redirect_target and ifid_valid <= 0 (flush), regardless of stall; redirect SHALL have priority over stall.
REQ-010 In RUN with redirect_valid=1 and redirect_target[1:0]!=0, the block SHALL set ifid_valid <= 0, err_code <= 1 and state <= HALT, with PC held.
REQ-011 In RUN, if PC >= 4*IMEM_WORDS and no redirect is pending, the block SHALL not capture; it SHALL set ifid_valid <= 0, err_code <= 2 and state <= HALT.
REQ-012 If a capture stores imem_rdata = 32'h0010_0073 (EBREAK), that capture SHALL complete normally and state SHALL become HALT on the same edge.
REQ-013 PC SHALL not advance past an EBREAK: PC <= PC, not PC+4.
REQ-014 In HALT, on the first edge ifid_valid <= 0, and thereafter it SHALL stay 0.
REQ-015 In HALT, PC, err_code and fetch_count SHALL hold, stall and redirect SHALL be ignored, and only reset SHALL exit.
REQ-016 PC+4 and fetch_count SHALL wrap modulo 2^32 with no flag.
REQ-017 halted SHALL be 1 exactly when state = HALT.

Reset
REQ-018 While rst_n=0, the block SHALL hold:
- state = BOOT;
- PC = RESET_VECTOR;
- ifid_valid = 0;
- ifid_pc, ifid_instr and ifid_pc_plus4 = 0;
- err_code = 0;
- fetch_count = 0;
- halted = 0.
REQ-019 Reset asserted mid-operation (including in HALT or during a stall) SHALL clear all state immediately, without waiting for a clock edge.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Reset release, stall=0, memory holding 0x00000013 everywhere -> cycle 1 ifid_valid=0 (BOOT); then ifid_pc = 0, 4, 8 on successive edges; fetch_count 1, 2, 3.
- stall=1 for 3 cycles after the capture of PC 8 -> ifid_pc=8 and imem_addr=12 held for 3 cycles; fetch_count unchanged; capture resumes at 12.
- redirect_valid=1, target 0x20, with stall=1 on the same edge -> next cycle ifid_valid=0, imem_addr=0x20; the following edge captures PC 0x20.
- redirect target 0x22 -> err_code=1, halted=1, ifid_valid=0, PC frozen; later stall/redirect activity ignored.
- EBREAK at word 3 -> captured with ifid_pc=12, then halted=1, imem_addr stays 12, ifid_valid=0 from the next cycle on; fetch_count=4.
- No redirect, run to PC 128 with IMEM_WORDS=32 -> err_code=2, halted=1; rst_n pulsed low asynchronously -> all outputs return to reset values before the next edge.
